// File: rtl/echo_pkg.sv
// Shared types and constants for the bash line processor: FSM states, mode codes
// and the ASCII case-mapping helper.
package echo_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StEmit,
        StDone,
        StWaitAck
    } state_e;

    localparam logic [1:0] ModeEcho    = 2'd0;
    localparam logic [1:0] ModeReverse = 2'd1;
    localparam logic [1:0] ModeUpper   = 2'd2;
    localparam logic [1:0] ModeLower   = 2'd3;

    localparam logic [7:0] AsciiLowerA    = 8'h61;
    localparam logic [7:0] AsciiLowerZ    = 8'h7A;
    localparam logic [7:0] AsciiUpperA    = 8'h41;
    localparam logic [7:0] AsciiUpperZ    = 8'h5A;
    localparam logic [7:0] AsciiCaseDelta = 8'h20;

    function automatic logic [7:0] map_case(input logic [1:0] mode, input logic [7:0] ch);
        logic [7:0] res;
        res = ch;
        if (mode == ModeUpper && ch >= AsciiLowerA && ch <= AsciiLowerZ) begin
            res = ch - AsciiCaseDelta;
        end else if (mode == ModeLower && ch >= AsciiUpperA && ch <= AsciiUpperZ) begin
            res = ch + AsciiCaseDelta;
        end
        return res;
    endfunction

endpackage

// File: rtl/bash_line_processor_if.sv
// Bash-side and consumer-side handshake bundle of the line processor.
// master = bash/consumer environment, slave = the processor.
interface bash_line_processor_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 6
);
    import echo_pkg::*;

    logic [1:0]        mode;
    logic              out_newASCII_ready;
    logic [LEN_W-1:0]  out_lineLen;
    logic [DATA_W-1:0] lineOut;
    logic              lineOut_nextASCII;
    logic              in_newASCII_ready;
    logic [DATA_W-1:0] lineIn;
    logic              lineIn_nextASCII;
    logic              in_solved;
    logic              out_solved;
    logic              overflow;
    logic [15:0]       line_count;

    modport master (
        output mode, out_newASCII_ready, out_lineLen, lineOut, lineIn_nextASCII, out_solved,
        input  lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved, overflow, line_count
    );

    modport slave (
        input  mode, out_newASCII_ready, out_lineLen, lineOut, lineIn_nextASCII, out_solved,
        output lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved, overflow, line_count
    );

endinterface

// File: rtl/echo_line_buffer.sv
// Line storage: MAX_LEN x DATA_W, one synchronous write port, one asynchronous read port.
// Contents are not reset.
module echo_line_buffer
    import echo_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned DATA_W  = 8,
    localparam int unsigned PTR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bash_line_processor.sv
// Captures a line from bash, then re-emits it echoed, reversed, upper- or lower-cased.
// Optional build macro LINE_COUNT_EN enables the completed-line counter.
module bash_line_processor
    import echo_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned DATA_W  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    bash_line_processor_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned PTR_W = $clog2(MAX_LEN);

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  rd_cnt_q;
    logic [LEN_W-1:0]  wr_idx_q;
    logic              phase_q;
    logic              pulse_q;
    logic              ready_q;
    logic              solved_q;
    logic              overflow_q;

    logic              consume;
    logic              store;
    logic [PTR_W-1:0]  raddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] char_mapped;

    // phase_q enforces the pulse/gap rhythm so bash has a cycle to present the next char
    assign consume = (state_q == StCapture) && bus.out_newASCII_ready && !phase_q &&
                     (rd_cnt_q < bus.out_lineLen) && (bus.lineOut != '0);
    assign store   = consume && (rd_cnt_q < LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= ModeEcho;
            rd_cnt_q   <= '0;
            wr_idx_q   <= '0;
            phase_q    <= 1'b0;
            pulse_q    <= 1'b0;
            ready_q    <= 1'b0;
            solved_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pulse_q  <= 1'b0;
            solved_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.out_newASCII_ready) begin
                        state_q    <= StCapture;
                        mode_q     <= bus.mode;
                        rd_cnt_q   <= '0;
                        phase_q    <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                StCapture: begin
                    if (!bus.out_newASCII_ready) begin
                        state_q  <= StEmit;
                        wr_idx_q <= '0;
                        ready_q  <= 1'b1;
                    end else if (phase_q) begin
                        phase_q <= 1'b0;
                    end else if (consume) begin
                        pulse_q <= 1'b1;
                        phase_q <= 1'b1;
                        if (store) begin
                            rd_cnt_q <= rd_cnt_q + LEN_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (bus.lineIn_nextASCII) begin
                        if (wr_idx_q == rd_cnt_q) begin
                            state_q  <= StDone;
                            ready_q  <= 1'b0;
                            solved_q <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_q + LEN_W'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (bus.out_solved) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    echo_line_buffer #(
        .MAX_LEN (MAX_LEN),
        .DATA_W  (DATA_W)
    ) u_buffer (
        .clk   (clk),
        .we    (store),
        .waddr (rd_cnt_q[PTR_W-1:0]),
        .wdata (bus.lineOut),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign raddr = (mode_q == ModeReverse) ? PTR_W'(rd_cnt_q - LEN_W'(1) - wr_idx_q)
                                           : PTR_W'(wr_idx_q);

    // Terminator slot (wr_idx == rd_cnt) and idle cycles both present 0
    always_comb begin
        char_mapped      = rdata;
        char_mapped[7:0] = map_case(mode_q, rdata[7:0]);
        if (!ready_q || (wr_idx_q == rd_cnt_q)) begin
            bus.lineIn = '0;
        end else begin
            bus.lineIn = char_mapped;
        end
    end

    assign bus.lineOut_nextASCII = pulse_q;
    assign bus.in_newASCII_ready = ready_q;
    assign bus.in_solved         = solved_q;
    assign bus.overflow          = overflow_q;

`ifdef LINE_COUNT_EN
    logic [15:0] line_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_count_q <= '0;
        end else if (solved_q) begin
            line_count_q <= line_count_q + 16'd1;
        end
    end

    assign bus.line_count = line_count_q;
`else
    assign bus.line_count = '0;
`endif

endmodule

// File: tb/tb_bash_line_processor.sv
// Scoreboard bench: a MAX_LEN=32 and a MAX_LEN=4 instance, selected by sel; the
// unselected instance sees its handshake inputs held low.
module tb_bash_line_processor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       bash_rdy = 1'b0;
    logic [7:0] line_len = 8'd0;
    logic [7:0] line_out = 8'd0;
    logic       take = 1'b0;
    logic       ack = 1'b0;
    logic       sel = 1'b0;

    int         n_vec = 0;
    int         n_err = 0;
    int         lines [2] = '{0, 0};
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    bash_line_processor_if #(.DATA_W(8), .LEN_W(6)) bus_a ();
    bash_line_processor_if #(.DATA_W(8), .LEN_W(3)) bus_b ();

    bash_line_processor #(.MAX_LEN(32), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    bash_line_processor #(.MAX_LEN(4), .DATA_W(8)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.mode               = mode;
    assign bus_a.out_newASCII_ready = bash_rdy & ~sel;
    assign bus_a.out_lineLen        = line_len[5:0];
    assign bus_a.lineOut            = line_out;
    assign bus_a.lineIn_nextASCII   = take & ~sel;
    assign bus_a.out_solved         = ack & ~sel;

    assign bus_b.mode               = mode;
    assign bus_b.out_newASCII_ready = bash_rdy & sel;
    assign bus_b.out_lineLen        = line_len[2:0];
    assign bus_b.lineOut            = line_out;
    assign bus_b.lineIn_nextASCII   = take & sel;
    assign bus_b.out_solved         = ack & sel;

    logic        o_pulse, o_rdy, o_solved, o_ovf;
    logic [7:0]  o_char;
    logic [15:0] o_cnt;

    assign o_pulse  = sel ? bus_b.lineOut_nextASCII : bus_a.lineOut_nextASCII;
    assign o_rdy    = sel ? bus_b.in_newASCII_ready : bus_a.in_newASCII_ready;
    assign o_char   = sel ? bus_b.lineIn            : bus_a.lineIn;
    assign o_solved = sel ? bus_b.in_solved         : bus_a.in_solved;
    assign o_ovf    = sel ? bus_b.overflow          : bus_a.overflow;
    assign o_cnt    = sel ? bus_b.line_count        : bus_a.line_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef LINE_COUNT_EN
        return lines[int'(sel)];
`else
        return 0;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_rdy"},    o_rdy, 0);
        check_eq({tag, "_pulse"},  o_pulse, 0);
        check_eq({tag, "_solved"}, o_solved, 0);
        check_eq({tag, "_ovf"},    o_ovf, 0);
        check_eq({tag, "_cnt"},    o_cnt, 0);
        check_eq({tag, "_char"},   o_char, 0);
    endtask

    // Reference: truncate to lim, optionally reverse, then case-map; terminator last
    task automatic push_expected(input string s, input logic [1:0] m, input int lim);
        int         n;
        logic [7:0] c;
        n = (s.len() < lim) ? s.len() : lim;
        for (int i = 0; i < n; i++) begin
            c = (m == 2'd1) ? s[n-1-i] : s[i];
            if (m == 2'd2 && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
            if (m == 2'd3 && c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
            exp_q.push_back(c);
        end
        exp_q.push_back(8'h00);
    endtask

    task automatic send_line(input string s);
        int idx = 0;
        int pulses = 0;
        int n = 0;
        @(negedge clk);
        line_len = 8'(s.len());
        line_out = (s.len() > 0) ? s[0] : 8'h00;
        bash_rdy = 1'b1;
        while (idx < s.len() && n < 200) begin
            @(negedge clk);
            n++;
            if (o_pulse) begin
                pulses++;
                idx++;
                line_out = (idx < s.len()) ? s[idx] : 8'h00;
            end
        end
        if (s.len() == 0) @(negedge clk);
        bash_rdy = 1'b0;
        line_out = 8'h00;
        check_eq("consume_cnt", pulses, s.len());
    endtask

    task automatic drain_line();
        int n = 0;
        bit seen = 1'b0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (o_rdy) begin
                check_eq("lineIn", o_char, exp_q.pop_front());
                take = 1'b1;
            end else begin
                take = 1'b0;
            end
        end
        if (exp_q.size() > 0) begin
            check_eq("emit_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            take = 1'b0;
            n++;
            seen = o_solved;
        end
        check_eq("in_solved", seen, 1);
        @(negedge clk);
        check_eq("solved_pulse", o_solved, 0);
        check_eq("rdy_after", o_rdy, 0);
    endtask

    task automatic ack_line();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic run_line(input string s, input logic [1:0] m, input bit exp_ovf);
        mode = m;
        push_expected(s, m, sel ? 4 : 32);
        send_line(s);
        drain_line();
        lines[int'(sel)]++;
        check_eq("line_count", o_cnt, exp_count());
        check_eq("overflow", o_ovf, exp_ovf);
        ack_line();
    endtask

    initial begin
        int hold;
        int got;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        run_line("ls -a", 2'd0, 1'b0);
        run_line("abc", 2'd1, 1'b0);
        run_line("aZ9", 2'd2, 1'b0);
        run_line("Q!", 2'd3, 1'b0);

        // Empty line, then no acknowledge: a new bash line must be ignored
        mode = 2'd0;
        push_expected("", 2'd0, 32);
        send_line("");
        drain_line();
        lines[0]++;
        check_eq("empty_count", o_cnt, exp_count());
        @(negedge clk);
        line_len = 8'd1;
        line_out = 8'h78;
        bash_rdy = 1'b1;
        hold = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_pulse || o_rdy) hold++;
        end
        check_eq("waitack_hold", hold, 0);
        bash_rdy = 1'b0;
        line_out = 8'h00;
        ack_line();

        // Reset after the second emitted character aborts the line
        mode = 2'd0;
        push_expected("hello", 2'd0, 32);
        send_line("hello");
        got = 0;
        hold = 0;
        while (got < 2 && hold < 50) begin
            @(negedge clk);
            hold++;
            if (o_rdy) begin
                check_eq("pre_reset_char", o_char, exp_q.pop_front());
                take = 1'b1;
                got++;
            end else begin
                take = 1'b0;
            end
        end
        @(negedge clk);
        take = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        lines = '{0, 0};
        @(negedge clk);
        check_idle("midreset");
        rst_n = 1'b1;
        hold = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_solved) hold++;
        end
        check_eq("abort_no_solved", hold, 0);
        run_line("x", 2'd0, 1'b0);

        // Truncation on the 4-deep instance, then overflow clears on the next line
        sel = 1'b1;
        run_line("abcdef", 2'd0, 1'b1);
        run_line("aB", 2'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
